iir_seq_ctrl: RTL and testbench

Sequencer and state-register bank for the second-order IIR lowpass datapath. It accepts one input sample per sample tick and drives the coefficient, data and addend select codes of `muxpb200` in a fixed five-step multiply-accumulate schedule. It latches each MAC result into the correct state or accumulator register and returns `fk`, `fk1`, `fk2`, `Uk`, `yk` and `acum1..3` to the mux. The shared MAC (product, `>>> F`, add) sits outside this block.

---
 rtl/iir_seq_ctrl_pkg.sv | 52 +++++
 rtl/iir_seq_ctrl.sv | 126 ++++++++++++
 tb/tb_iir_seq_ctrl.sv | 371 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/iir_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : iir_seq_ctrl_pkg
// Description : Word widths, mux select encodings and sequencer state codes
//               shared by the IIR lowpass datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package iir_seq_ctrl_pkg;

    localparam int N = 32;
    localparam int F = 14;

    // Coefficient select (controlS)
    localparam logic [2:0] SEL_ZERO  = 3'd0;
    localparam logic [2:0] SEL_A1    = 3'd1;
    localparam logic [2:0] SEL_A2    = 3'd2;
    localparam logic [2:0] SEL_B0    = 3'd3;
    localparam logic [2:0] SEL_B1    = 3'd4;
    localparam logic [2:0] SEL_B2    = 3'd5;

    // Data select (controlC)
    localparam logic [1:0] SEL_FK1   = 2'd1;
    localparam logic [1:0] SEL_FK2   = 2'd2;
    localparam logic [1:0] SEL_FK    = 2'd3;

    // Addend select (controlZ)
    localparam logic [2:0] SEL_UK    = 3'd1;
    localparam logic [2:0] SEL_YK    = 3'd2;
    localparam logic [2:0] SEL_ACUM1 = 3'd3;
    localparam logic [2:0] SEL_ACUM2 = 3'd4;
    localparam logic [2:0] SEL_ACUM3 = 3'd5;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_M1     = 3'd1;
    localparam logic [2:0] ST_M2     = 3'd2;
    localparam logic [2:0] ST_M3     = 3'd3;
    localparam logic [2:0] ST_M4     = 3'd4;
    localparam logic [2:0] ST_M5     = 3'd5;
    localparam logic [2:0] ST_SHIFT  = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_M1    = ST_M1,
        S_M2    = ST_M2,
        S_M3    = ST_M3,
        S_M4    = ST_M4,
        S_M5    = ST_M5,
        S_SHIFT = ST_SHIFT
    } state_t;

endpackage
`default_nettype wire

// File: rtl/iir_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : iir_seq_ctrl
// Description : Five-step MAC sequencer and state-register bank for the
//               second-order IIR lowpass; the MAC and muxes live outside.
// Revision    : 1.0 - initial release
// ============================================================================
module iir_seq_ctrl
    import iir_seq_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                sample_tick,
    input  logic signed [N-1:0] u_in,
    input  logic signed [N-1:0] mac,
    output logic [2:0]          controlS,
    output logic [1:0]          controlC,
    output logic [2:0]          controlZ,
    output logic signed [N-1:0] Uk,
    output logic signed [N-1:0] fk,
    output logic signed [N-1:0] fk1,
    output logic signed [N-1:0] fk2,
    output logic signed [N-1:0] acum1,
    output logic signed [N-1:0] acum2,
    output logic signed [N-1:0] acum3,
    output logic signed [N-1:0] yk,
    output logic                y_valid,
    output logic                busy,
    output logic                overrun
);

    state_t r_state;
    state_t w_next;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Outputs depend on r_state only; sample_tick affects just the next state.
    always_comb begin
        w_next   = r_state;
        controlS = SEL_ZERO;
        controlC = SEL_ZERO[1:0];
        controlZ = SEL_ZERO;
        busy     = 1'b1;
        y_valid  = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (sample_tick) w_next = S_M1;
            end
            S_M1: begin
                controlS = SEL_A1;
                controlC = SEL_FK1;
                controlZ = SEL_UK;
                w_next   = S_M2;
            end
            S_M2: begin
                controlS = SEL_A2;
                controlC = SEL_FK2;
                controlZ = SEL_ACUM1;
                w_next   = S_M3;
            end
            S_M3: begin
                controlS = SEL_B0;
                controlC = SEL_FK;
                w_next   = S_M4;
            end
            S_M4: begin
                controlS = SEL_B1;
                controlC = SEL_FK1;
                controlZ = SEL_ACUM2;
                w_next   = S_M5;
            end
            S_M5: begin
                controlS = SEL_B2;
                controlC = SEL_FK2;
                controlZ = SEL_ACUM3;
                w_next   = S_SHIFT;
            end
            S_SHIFT: begin
                y_valid = 1'b1;
                w_next  = S_IDLE;
            end
            default: begin
                busy   = 1'b0;
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            Uk      <= '0;
            fk      <= '0;
            fk1     <= '0;
            fk2     <= '0;
            acum1   <= '0;
            acum2   <= '0;
            acum3   <= '0;
            yk      <= '0;
            overrun <= 1'b0;
        end else begin
            if (sample_tick && (r_state != S_IDLE)) overrun <= 1'b1;
            case (r_state)
                S_IDLE:  if (sample_tick) Uk <= u_in;
                S_M1:    acum1 <= mac;
                S_M2:    fk    <= mac;
                S_M3:    acum2 <= mac;
                S_M4:    acum3 <= mac;
                S_M5:    yk    <= mac;
                S_SHIFT: begin
                    fk2 <= fk1;
                    fk1 <= fk;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_iir_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_iir_seq_ctrl
// Description : Directed self-checking bench for iir_seq_ctrl with a
//               behavioural select-mux and MAC wrapped around it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iir_seq_ctrl;
    import iir_seq_ctrl_pkg::*;

    localparam longint A1 = 32112;
    localparam longint A2 = -15736;
    localparam longint B0 = 3;
    localparam longint B1 = 6;
    localparam longint B2 = 3;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic                sample_tick = 1'b0;
    logic signed [N-1:0] u_in = '0;
    logic signed [N-1:0] mac;
    logic [2:0]          controlS;
    logic [1:0]          controlC;
    logic [2:0]          controlZ;
    logic signed [N-1:0] Uk, fk, fk1, fk2, acum1, acum2, acum3, yk;
    logic                y_valid, busy, overrun;

    int n_cmp = 0;
    int n_err = 0;

    longint m_c, m_d, m_z, m_t;

    always #5 clk = ~clk;

    iir_seq_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .sample_tick (sample_tick),
        .u_in        (u_in),
        .mac         (mac),
        .controlS    (controlS),
        .controlC    (controlC),
        .controlZ    (controlZ),
        .Uk          (Uk),
        .fk          (fk),
        .fk1         (fk1),
        .fk2         (fk2),
        .acum1       (acum1),
        .acum2       (acum2),
        .acum3       (acum3),
        .yk          (yk),
        .y_valid     (y_valid),
        .busy        (busy),
        .overrun     (overrun)
    );

    // muxpb200 + shared MAC model
    always_comb begin
        m_c = 0;
        m_d = 0;
        m_z = 0;
        case (controlS)
            3'd1: m_c = A1;
            3'd2: m_c = A2;
            3'd3: m_c = B0;
            3'd4: m_c = B1;
            3'd5: m_c = B2;
            default: m_c = 0;
        endcase
        case (controlC)
            2'd1: m_d = longint'(fk1);
            2'd2: m_d = longint'(fk2);
            2'd3: m_d = longint'(fk);
            default: m_d = 0;
        endcase
        case (controlZ)
            3'd1: m_z = longint'(Uk);
            3'd2: m_z = longint'(yk);
            3'd3: m_z = longint'(acum1);
            3'd4: m_z = longint'(acum2);
            3'd5: m_z = longint'(acum3);
            default: m_z = 0;
        endcase
        m_t = ((m_c * m_d) >>> F) + m_z;
        mac = N'(m_t);
    end

    function automatic longint to_n(input longint x);
        logic signed [N-1:0] t;
        t = N'(x);
        return longint'(t);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset       = 1'b0;
        sample_tick = 1'b1;
        u_in        = 1234;
        step();
        step();
        n_cmp++;
        if ({busy, y_valid, overrun, controlS, controlC, controlZ} !== 11'd0) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b, expected 0", {busy, y_valid, overrun, controlS, controlC, controlZ});
        end
        n_cmp++;
        if ({Uk, fk, fk1, fk2, acum1, acum2, acum3, yk} !== '0) begin
            n_err++;
            $display("FAIL reset_regs: got Uk=%0d yk=%0d fk=%0d, expected all 0", Uk, yk, fk);
        end
        sample_tick = 1'b0;
        reset       = 1'b1;
        step();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_tick_ignored: got busy=%b, expected 0", busy);
        end
    endtask

    task automatic test_first_sample();
        int es[7] = '{0, 1, 2, 3, 4, 5, 0};
        int ec[7] = '{0, 1, 2, 3, 1, 2, 0};
        int ez[7] = '{0, 1, 3, 0, 4, 5, 0};
        n_cmp++;
        if ({controlS, controlC, controlZ, busy} !== 9'd0) begin
            n_err++;
            $display("FAIL trace_c0: got S=%0d C=%0d Z=%0d busy=%b, expected 0,0,0,0", controlS, controlC, controlZ, busy);
        end
        sample_tick = 1'b1;
        u_in        = 16384;
        for (int c = 1; c <= 6; c++) begin
            step();
            sample_tick = 1'b0;
            n_cmp++;
            if (int'(controlS) != es[c] || int'(controlC) != ec[c] || int'(controlZ) != ez[c]) begin
                n_err++;
                $display("FAIL trace_sel c%0d: got S=%0d C=%0d Z=%0d, expected %0d,%0d,%0d",
                         c, controlS, controlC, controlZ, es[c], ec[c], ez[c]);
            end
            n_cmp++;
            if (busy !== 1'b1 || y_valid !== (c == 6)) begin
                n_err++;
                $display("FAIL trace_flags c%0d: got busy=%b y_valid=%b, expected 1,%b", c, busy, y_valid, c == 6);
            end
        end
        n_cmp++;
        if (yk !== 3) begin
            n_err++;
            $display("FAIL first_yk: got %0d, expected 3", yk);
        end
        step();
        n_cmp++;
        if (busy !== 1'b0 || y_valid !== 1'b0) begin
            n_err++;
            $display("FAIL first_c7_flags: got busy=%b y_valid=%b, expected 0,0", busy, y_valid);
        end
        n_cmp++;
        if (fk1 !== 16384 || fk2 !== 0 || acum1 !== 16384 || Uk !== 16384) begin
            n_err++;
            $display("FAIL first_state: got fk1=%0d fk2=%0d acum1=%0d Uk=%0d, expected 16384,0,16384,16384",
                     fk1, fk2, acum1, Uk);
        end
    endtask

    task automatic test_second_sample();
        sample_tick = 1'b1;
        u_in        = 0;
        step();
        sample_tick = 1'b0;
        repeat (5) step();
        n_cmp++;
        if (y_valid !== 1'b1 || yk !== 11) begin
            n_err++;
            $display("FAIL second_yk: got y_valid=%b yk=%0d, expected 1,11", y_valid, yk);
        end
        n_cmp++;
        if (acum1 !== 32112 || fk !== 32112 || acum2 !== 5 || acum3 !== 11) begin
            n_err++;
            $display("FAIL second_acc: got acum1=%0d fk=%0d acum2=%0d acum3=%0d, expected 32112,32112,5,11",
                     acum1, fk, acum2, acum3);
        end
        step();
        n_cmp++;
        if (fk1 !== 32112 || fk2 !== 16384) begin
            n_err++;
            $display("FAIL second_shift: got fk1=%0d fk2=%0d, expected 32112,16384", fk1, fk2);
        end
    endtask

    task automatic test_overrun_mid();
        pulse_reset();
        n_cmp++;
        if (overrun !== 1'b0) begin
            n_err++;
            $display("FAIL ovr_clear: got %b, expected 0", overrun);
        end
        sample_tick = 1'b1;
        u_in        = 16384;
        step();
        sample_tick = 1'b0;
        step();
        step();
        sample_tick = 1'b1;
        u_in        = 999;
        step();
        sample_tick = 1'b0;
        n_cmp++;
        if (overrun !== 1'b1 || Uk !== 16384 || controlS !== 3'd4) begin
            n_err++;
            $display("FAIL ovr_mid: got overrun=%b Uk=%0d S=%0d, expected 1,16384,4", overrun, Uk, controlS);
        end
        step();
        step();
        n_cmp++;
        if (y_valid !== 1'b1 || yk !== 3) begin
            n_err++;
            $display("FAIL ovr_yk: got y_valid=%b yk=%0d, expected 1,3", y_valid, yk);
        end
        step();
        sample_tick = 1'b1;
        u_in        = 0;
        step();
        sample_tick = 1'b0;
        n_cmp++;
        if (busy !== 1'b1 || Uk !== 0) begin
            n_err++;
            $display("FAIL ovr_c7_accept: got busy=%b Uk=%0d, expected 1,0", busy, Uk);
        end
        repeat (5) step();
        n_cmp++;
        if (y_valid !== 1'b1 || yk !== 11 || overrun !== 1'b1) begin
            n_err++;
            $display("FAIL ovr_sticky: got y_valid=%b yk=%0d overrun=%b, expected 1,11,1", y_valid, yk, overrun);
        end
        step();
    endtask

    task automatic test_overrun_shift();
        pulse_reset();
        sample_tick = 1'b1;
        u_in        = 16384;
        step();
        sample_tick = 1'b0;
        repeat (5) step();
        sample_tick = 1'b1;
        u_in        = 777;
        step();
        sample_tick = 1'b0;
        n_cmp++;
        if (overrun !== 1'b1 || busy !== 1'b0 || Uk !== 16384 || fk1 !== 16384) begin
            n_err++;
            $display("FAIL ovr_shift: got overrun=%b busy=%b Uk=%0d fk1=%0d, expected 1,0,16384,16384",
                     overrun, busy, Uk, fk1);
        end
    endtask

    task automatic test_reset_mid();
        int bad_valid;
        pulse_reset();
        sample_tick = 1'b1;
        u_in        = 16384;
        step();
        sample_tick = 1'b0;
        repeat (6) step();
        sample_tick = 1'b1;
        u_in        = 0;
        step();
        sample_tick = 1'b0;
        step();
        step();
        step();
        n_cmp++;
        if (controlS !== 3'd4) begin
            n_err++;
            $display("FAIL rmid_in_m4: got S=%0d, expected 4", controlS);
        end
        reset = 1'b0;
        step();
        reset = 1'b1;
        n_cmp++;
        if ({busy, y_valid, overrun, controlS, controlC, controlZ} !== 11'd0) begin
            n_err++;
            $display("FAIL rmid_ctrl: got %b, expected 0", {busy, y_valid, overrun, controlS, controlC, controlZ});
        end
        n_cmp++;
        if ({Uk, fk, fk1, fk2, acum1, acum2, acum3, yk} !== '0) begin
            n_err++;
            $display("FAIL rmid_regs: got fk1=%0d acum3=%0d yk=%0d, expected all 0", fk1, acum3, yk);
        end
        bad_valid = 0;
        repeat (3) begin
            step();
            if (y_valid !== 1'b0) bad_valid++;
        end
        n_cmp++;
        if (bad_valid != 0) begin
            n_err++;
            $display("FAIL rmid_no_valid: got %0d y_valid cycles, expected 0", bad_valid);
        end
        sample_tick = 1'b1;
        u_in        = 16384;
        step();
        sample_tick = 1'b0;
        repeat (5) step();
        n_cmp++;
        if (y_valid !== 1'b1 || yk !== 3) begin
            n_err++;
            $display("FAIL rmid_resume: got y_valid=%b yk=%0d, expected 1,3", y_valid, yk);
        end
        step();
    endtask

    task automatic test_back_to_back();
        longint w1, w2, w, a1v, a2v, a3v, yref;
        int     u;
        pulse_reset();
        w1 = 0;
        w2 = 0;
        for (int s = 0; s < 100; s++) begin
            u    = int'($urandom_range(2000)) - 1000;
            a1v  = to_n(((A1 * w1) >>> F) + longint'(u));
            w    = to_n(((A2 * w2) >>> F) + a1v);
            a2v  = to_n((B0 * w) >>> F);
            a3v  = to_n(((B1 * w1) >>> F) + a2v);
            yref = to_n(((B2 * w2) >>> F) + a3v);
            w2   = w1;
            w1   = w;
            sample_tick = 1'b1;
            u_in        = u;
            step();
            sample_tick = 1'b0;
            repeat (5) step();
            n_cmp++;
            if (y_valid !== 1'b1 || longint'(yk) !== yref) begin
                n_err++;
                $display("FAIL b2b_yk s%0d: got y_valid=%b yk=%0d, expected 1,%0d", s, y_valid, yk, yref);
            end
            step();
        end
        n_cmp++;
        if (overrun !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_overrun: got %b, expected 0", overrun);
        end
    endtask

    initial begin
        test_reset();
        test_first_sample();
        test_second_sample();
        test_overrun_mid();
        test_overrun_shift();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
